// File: rtl/fp_issue_ctrl.sv
// FP issue sequencer: accepts FP requests, resolves the dynamic rounding mode,
// pulses the FPU enable, queues results in a FWFT response FIFO and keeps sticky fflags.
package fp_issue_pkg;

  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmadd;
    logic fnmsub;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fsgnj;
    logic fcmp;
    logic fmax;
    logic fclass;
    logic fcvt_f2i;
    logic fcvt_i2f;
    logic fmv;
  } fp_operation_type;

  typedef struct packed {
    logic [63:0]      data1;
    logic [63:0]      data2;
    logic [63:0]      data3;
    fp_operation_type op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

endpackage

module fp_issue_ctrl
  import fp_issue_pkg::*;
#(
  parameter int TAG_W     = 5,
  parameter int RSP_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_data1,
  input  logic [63:0]      req_data2,
  input  logic [63:0]      req_data3,
  input  fp_operation_type req_op,
  input  logic [1:0]       req_fmt,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       frm,
  output fp_exe_in_type    fp_exe_i,
  input  fp_exe_out_type   fp_exe_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             flush,
  input  logic             fflags_clr,
  output logic [4:0]       fflags,
  output logic             busy
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [63:0]      result;
    logic [4:0]       flags;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } rsp_entry_t;

  state_t           state_reg, state_next;
  fp_exe_in_type    exe_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [4:0]       fflags_reg, fflags_next;
  rsp_entry_t       mem [RSP_DEPTH];

  logic [2:0]  eff_rm;
  logic        rm_illegal;
  logic        accept;
  logic        fu_push;
  logic        push;
  logic        pop;
  rsp_entry_t  push_entry;
  rsp_entry_t  head;

  assign eff_rm     = (req_rm == 3'b111) ? frm : req_rm;
  assign rm_illegal = (eff_rm == 3'b101) || (eff_rm[2:1] == 2'b11);

  // Credit check against the FIFO: an accepted op always has a slot waiting for it.
  assign req_ready = (state_reg == IDLE) && (count_reg != CNT_W'(RSP_DEPTH)) && !flush && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    fu_push    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && !rm_illegal) state_next = ISSUE;
      end
      ISSUE: begin
        if (fp_exe_o.ready) begin
          state_next = IDLE;
          fu_push    = !flush;
        end else begin
          state_next = flush ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (fp_exe_o.ready) begin
          state_next = IDLE;
          fu_push    = !flush;
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fp_exe_o.ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The two push sources are exclusive: illegal requests only arrive in IDLE.
  assign push = fu_push || (accept && rm_illegal);

  always_comb begin
    push_entry = '0;
    if (fu_push) begin
      push_entry.result = fp_exe_o.result;
      push_entry.flags  = fp_exe_o.flags;
      push_entry.tag    = tag_reg;
    end else begin
      push_entry.illegal = 1'b1;
      push_entry.tag     = req_tag;
    end
  end

  assign head      = mem[rd_ptr_reg];
  assign rsp_valid = (count_reg != '0);
  assign pop       = rsp_valid && rsp_ready && !flush;

  assign rsp_result  = rsp_valid ? head.result  : 64'd0;
  assign rsp_flags   = rsp_valid ? head.flags   : 5'd0;
  assign rsp_illegal = rsp_valid ? head.illegal : 1'b0;
  assign rsp_tag     = rsp_valid ? head.tag     : '0;

  assign fflags_next = (fflags_clr ? 5'd0 : fflags_reg) | (pop ? head.flags : 5'd0);
  assign fflags      = fflags_reg;
  assign busy        = (state_reg != IDLE);

  always_comb begin
    fp_exe_i        = exe_reg;
    fp_exe_i.enable = (state_reg == ISSUE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      exe_reg    <= '0;
      tag_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      fflags_reg <= '0;
    end else begin
      state_reg  <= state_next;
      fflags_reg <= fflags_next;
      if (accept && !rm_illegal) begin
        exe_reg.data1  <= req_data1;
        exe_reg.data2  <= req_data2;
        exe_reg.data3  <= req_data3;
        exe_reg.op     <= req_op;
        exe_reg.fmt    <= req_fmt;
        exe_reg.rm     <= eff_rm;
        exe_reg.enable <= 1'b0;
        tag_reg        <= req_tag;
      end
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl: table of rounding-mode vectors plus
// hand-written sequences for backpressure, flush, flag-clear race and reset mid-op.
module tb_fp_issue_ctrl;
  import fp_issue_pkg::*;

  localparam int TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_data1, req_data2, req_data3;
  fp_operation_type req_op;
  logic [1:0]       req_fmt;
  logic [2:0]       req_rm;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       frm;
  fp_exe_in_type    fp_exe_i;
  fp_exe_out_type   fpu_o;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic             rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;
  logic             flush;
  logic             fflags_clr;
  logic [4:0]       fflags;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (fp_exe_i.enable) en_cnt++;

  fp_issue_ctrl #(.TAG_W(TAG_W), .RSP_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
    .req_op(req_op), .req_fmt(req_fmt), .req_rm(req_rm), .req_tag(req_tag),
    .frm(frm), .fp_exe_i(fp_exe_i), .fp_exe_o(fpu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .flush(flush), .fflags_clr(fflags_clr), .fflags(fflags), .busy(busy)
  );

  typedef struct {
    logic [2:0] rm;
    logic [2:0] frm;
    logic       illegal;
    logic [2:0] exp_rm;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [2:0] rm, input logic [2:0] f,
                         input logic [TAG_W-1:0] tag, input logic [63:0] d);
    req_valid  = 1'b1;
    req_rm     = rm;
    frm        = f;
    req_tag    = tag;
    req_data1  = d;
    req_data2  = ~d;
    req_data3  = d ^ 64'h5555;
    req_op     = '0;
    req_op.fadd = 1'b1;
    req_fmt    = 2'b01;
  endtask

  task automatic fpu_ret(input logic [63:0] r, input logic [4:0] fl);
    fpu_o.ready  = 1'b1;
    fpu_o.result = r;
    fpu_o.flags  = fl;
  endtask

  // Legal op whose FPU answer arrives in the enable cycle; ends with the result queued.
  task automatic issue_quick(input logic [TAG_W-1:0] tag, input logic [63:0] d,
                             input logic [63:0] res, input logic [4:0] fl);
    set_req(3'b001, 3'b000, tag, d);
    #1;
    check("quick_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    fpu_ret(res, fl);
    #1;
    check("quick_enable", fp_exe_i.enable, 1);
    check("quick_rm", fp_exe_i.rm, 3'b001);
    tick();
    fpu_o = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 3'b111, 1'b0, 3'b000};
    vecs[1] = '{3'b100, 3'b001, 1'b0, 3'b100};
    vecs[2] = '{3'b111, 3'b000, 1'b0, 3'b000};
    vecs[3] = '{3'b111, 3'b100, 1'b0, 3'b100};
    vecs[4] = '{3'b111, 3'b011, 1'b0, 3'b011};
    vecs[5] = '{3'b111, 3'b101, 1'b1, 3'b000};
    vecs[6] = '{3'b111, 3'b111, 1'b1, 3'b000};
    vecs[7] = '{3'b110, 3'b000, 1'b1, 3'b000};
    vecs[8] = '{3'b101, 3'b001, 1'b1, 3'b000};

    reset = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    fpu_o = '0;
    set_req(3'b000, 3'b000, '0, 64'd0);
    tick();
    tick();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_enable", fp_exe_i.enable, 0);
    check("rst_data1", fp_exe_i.data1, 0);
    check("rst_rm", fp_exe_i.rm, 0);
    check("rst_fflags", fflags, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", req_ready, 1);

    // Rounding-mode table
    for (int i = 0; i < 9; i++) begin
      int e0;
      e0 = en_cnt;
      set_req(vecs[i].rm, vecs[i].frm, TAG_W'(i), 64'(i) * 64'h1111 + 64'd1);
      #1;
      check("tbl_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      if (vecs[i].illegal) begin
        #1;
        check("tbl_ill_valid", rsp_valid, 1);
        check("tbl_ill_flag", rsp_illegal, 1);
        check("tbl_ill_result", rsp_result, 0);
        check("tbl_ill_enable", fp_exe_i.enable, 0);
        check("tbl_ill_tag", rsp_tag, 64'(i));
      end else begin
        fpu_ret(64'hA000 + 64'(i), 5'b00000);
        #1;
        check("tbl_enable", fp_exe_i.enable, 1);
        check("tbl_rm", fp_exe_i.rm, vecs[i].exp_rm);
        check("tbl_data1", fp_exe_i.data1, 64'(i) * 64'h1111 + 64'd1);
        check("tbl_early_valid", rsp_valid, 0);
        tick();
        fpu_o = '0;
        #1;
        check("tbl_valid", rsp_valid, 1);
        check("tbl_illegal", rsp_illegal, 0);
        check("tbl_result", rsp_result, 64'hA000 + 64'(i));
        check("tbl_tag", rsp_tag, 64'(i));
        check("tbl_en_pulses", en_cnt - e0, 1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      check("tbl_drained", rsp_valid, 0);
      $display("vector %0d rm=%b frm=%b illegal=%0b", i, vecs[i].rm, vecs[i].frm, vecs[i].illegal);
    end

    // Dynamic rm, FPU answers three cycles after enable
    begin
      int e0;
      e0 = en_cnt;
      set_req(3'b111, 3'b010, 5'd3, 64'h4000_0000_0000_0000);
      #1;
      check("dyn_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      #1;
      check("dyn_enable", fp_exe_i.enable, 1);
      check("dyn_rm", fp_exe_i.rm, 3'b010);
      check("dyn_busy", busy, 1);
      tick();
      #1;
      check("dyn_wait_enable", fp_exe_i.enable, 0);
      check("dyn_wait_rm", fp_exe_i.rm, 3'b010);
      check("dyn_wait_data1", fp_exe_i.data1, 64'h4000_0000_0000_0000);
      tick();
      tick();
      fpu_ret(64'h4008_0000_0000_0000, 5'b00101);
      tick();
      fpu_o = '0;
      #1;
      check("dyn_valid", rsp_valid, 1);
      check("dyn_tag", rsp_tag, 3);
      check("dyn_result", rsp_result, 64'h4008_0000_0000_0000);
      check("dyn_flags", rsp_flags, 5'b00101);
      check("dyn_fflags_before_pop", fflags, 0);
      check("dyn_busy_done", busy, 0);
      check("dyn_en_pulses", en_cnt - e0, 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      check("dyn_fflags", fflags, 5'b00101);
      check("dyn_empty", rsp_valid, 0);
      $display("dynamic rm sequence done");
    end

    // Illegal static rm
    begin
      int e0;
      e0 = en_cnt;
      set_req(3'b101, 3'b000, 5'd12, 64'h77);
      #1;
      check("ill_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      #1;
      check("ill_valid", rsp_valid, 1);
      check("ill_flag", rsp_illegal, 1);
      check("ill_flags", rsp_flags, 0);
      check("ill_tag", rsp_tag, 12);
      check("ill_busy", busy, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      check("ill_fflags", fflags, 5'b00101);
      check("ill_no_enable", en_cnt - e0, 0);
      $display("illegal rm sequence done");
    end

    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    #1;
    check("clr_fflags", fflags, 0);

    // Backpressure with two entries
    issue_quick(5'd10, 64'h10, 64'hAAAA, 5'b00010);
    #1;
    check("bp_ready_one", req_ready, 1);
    issue_quick(5'd11, 64'h11, 64'hBBBB, 5'b01000);
    set_req(3'b001, 3'b000, 5'd20, 64'h20);
    #1;
    check("bp_ready_full", req_ready, 0);
    check("bp_idle", busy, 0);
    check("bp_head_tag", rsp_tag, 10);
    check("bp_head_result", rsp_result, 64'hAAAA);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    #1;
    check("bp_ready_back", req_ready, 1);
    check("bp_not_accepted", busy, 0);
    check("bp_second_tag", rsp_tag, 11);
    check("bp_second_result", rsp_result, 64'hBBBB);
    check("bp_fflags1", fflags, 5'b00010);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("bp_empty", rsp_valid, 0);
    check("bp_fflags2", fflags, 5'b01010);
    $display("backpressure sequence done");

    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;

    // Flush in WAIT, late answer discarded
    set_req(3'b000, 3'b000, 5'd7, 64'h7);
    tick();
    req_valid = 1'b0;
    #1;
    check("fw_enable", fp_exe_i.enable, 1);
    tick();
    flush = 1'b1;
    #1;
    check("fw_flush_req_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fw_drain_busy", busy, 1);
    check("fw_drain_enable", fp_exe_i.enable, 0);
    check("fw_drain_req_ready", req_ready, 0);
    tick();
    tick();
    tick();
    fpu_ret(64'hDEAD, 5'b00001);
    #1;
    check("fw_busy_until_ready", busy, 1);
    tick();
    fpu_o = '0;
    #1;
    check("fw_idle", busy, 0);
    check("fw_no_rsp", rsp_valid, 0);
    check("fw_fflags", fflags, 0);
    check("fw_req_ready", req_ready, 1);
    $display("flush in wait sequence done");

    // Flush in ISSUE with ready, queued entry also dropped
    issue_quick(5'd13, 64'h13, 64'h1313, 5'b00011);
    set_req(3'b000, 3'b000, 5'd14, 64'h14);
    tick();
    req_valid = 1'b0;
    fpu_ret(64'h1414, 5'b00100);
    flush = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("fi_enable", fp_exe_i.enable, 1);
    tick();
    flush = 1'b0;
    rsp_ready = 1'b0;
    fpu_o = '0;
    #1;
    check("fi_no_rsp", rsp_valid, 0);
    check("fi_idle", busy, 0);
    check("fi_fflags", fflags, 0);
    $display("flush in issue sequence done");

    // Clear racing a flag pop
    issue_quick(5'd15, 64'h15, 64'h1515, 5'b00100);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("race_pre_fflags", fflags, 5'b00100);
    issue_quick(5'd16, 64'h16, 64'h1616, 5'b10000);
    rsp_ready = 1'b1;
    fflags_clr = 1'b1;
    tick();
    rsp_ready = 1'b0;
    fflags_clr = 1'b0;
    #1;
    check("race_fflags", fflags, 5'b10000);
    $display("flag clear race sequence done");

    // Reset in WAIT, late FPU answer ignored
    set_req(3'b011, 3'b000, 5'd9, 64'h99);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mr_req_ready_in_reset", req_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_enable", fp_exe_i.enable, 0);
    check("mr_data1", fp_exe_i.data1, 0);
    check("mr_rm", fp_exe_i.rm, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_fflags", fflags, 0);
    check("mr_req_ready", req_ready, 1);
    fpu_ret(64'hBAD, 5'b11111);
    tick();
    fpu_o = '0;
    #1;
    check("mr_late_no_rsp", rsp_valid, 0);
    check("mr_late_fflags", fflags, 0);
    check("mr_late_busy", busy, 0);
    issue_quick(5'd4, 64'h44, 64'h1234, 5'b00001);
    #1;
    check("mr_next_valid", rsp_valid, 1);
    check("mr_next_tag", rsp_tag, 4);
    check("mr_next_result", rsp_result, 64'h1234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("mr_next_fflags", fflags, 5'b00001);
    $display("reset mid-op sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
- Initiator-side sequencer for the FPU execute interface. It takes FP requests from the integer pipeline over a valid/ready handshake, resolves the dynamic rounding mode, and drives fp_exe_in_type with a one-cycle enable pulse.
- It then waits for fp_exe_out_type.ready and queues the result with its tag in a response FIFO.
- It maintains the sticky fflags accumulator for the CSR file and supports pipeline flush of an in-flight operation.

Parameters:
- TAG_W, 5, width of request/response tag.
- RSP_DEPTH, 2, response FIFO entries (power of two, >=2).

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_data1/req_data2/req_data3  input  64 each  operands
- req_op  input  fp_operation_type  operation decode
- req_fmt  input  2  format
- req_rm  input  3  instruction rounding mode (111 = dynamic)
- req_tag  input  TAG_W  request tag
- frm  input  3  CSR rounding mode
- fp_exe_i  output  fp_exe_in_type  FPU command
- fp_exe_o  input  fp_exe_out_type  FPU result
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_result  output  64  result
- rsp_flags  output  5  exception flags
- rsp_illegal  output  1  request had illegal rounding mode
- rsp_tag  output  TAG_W  echoed tag
- flush  input  1  kill in-flight op and queued responses
- fflags_clr  input  1  clear sticky flags
- fflags  output  5  sticky accumulated flags
- busy  output  1  state != IDLE

Behaviour:
- Reset values:
  - state=IDLE.
  - fp_exe_i all fields 0, including enable.
  - FIFO empty, rsp_valid=0, rsp_result/flags/tag/illegal=0.
  - fflags=0, req_ready=0 during reset, busy=0.
- Effective rm: eff_rm = (req_rm==111) ? frm : req_rm. Illegal when eff_rm is 101, 110 or 111.
- Credit: free = RSP_DEPTH - fifo_count. req_ready = (state==IDLE) && free>0 && !flush && !reset. The issued op is already counted at acceptance, so an FPU result never finds the FIFO full.
- States:
  - IDLE:
    - Accept with illegal eff_rm: push {result=0, flags=0, illegal=1, tag} into the FIFO the next cycle; stay IDLE; no FPU enable.
    - Accept with legal eff_rm: register data1..3, op, fmt, eff_rm into fp_exe_i, plus tag; go to ISSUE.
  - ISSUE: fp_exe_i.enable=1 for exactly this one cycle.
    - fp_exe_o.ready sampled high this cycle: push and go to IDLE.
    - Otherwise go to WAIT.
  - WAIT: enable=0; fp_exe_i fields held.
    - On fp_exe_o.ready: push {fp_exe_o.result, fp_exe_o.flags, illegal=0, tag}; go to IDLE.
  - DRAIN: wait for fp_exe_o.ready, discard the result (no push, no flag accumulation), go to IDLE.
- Latency: acceptance at cycle T gives enable at T+1. The earliest rsp_valid is T+2 when the FPU returns ready in the enable cycle. Max throughput is one op per 2 cycles.
- FIFO:
  - First-word fall-through; rsp_* reflect the head entry.
  - Push and pop in the same cycle are allowed at any occupancy, and the count is unchanged.
  - Pointers wrap modulo RSP_DEPTH.
- fflags: next = (fflags_clr ? 0 : fflags) | (pop ? head.flags : 0). Illegal entries contribute 0. A flags pop in the same cycle as clear survives the clear.
- Flush (highest priority after reset):
  - FIFO emptied that cycle; rsp_valid=0 the next cycle; any pop that cycle is ignored for fflags.
  - No request accepted that cycle.
  - ISSUE: enable is still driven this cycle; next state is DRAIN, or IDLE if ready is seen this cycle.
  - WAIT: go to DRAIN, or IDLE if ready is seen this cycle. In both cases the result is discarded.
  - IDLE/DRAIN: state unchanged.
- fp_exe_o.ready while IDLE is ignored.
- Reset mid-operation returns everything to reset values next cycle. A late fp_exe_o.ready after reset is ignored because state is IDLE.

Test Plan:
- Dynamic rm: frm=010, req_rm=111, fadd, tag=3, FPU ready 3 cycles after enable.
  - fp_exe_i.rm=010, enable high exactly 1 cycle.
  - rsp_valid with tag=3 and the returned result/flags.
  - fflags=flags after pop.
- Illegal rm: req_rm=101.
  - No enable.
  - Next cycle rsp_valid, rsp_illegal=1, result=0, flags=0; fflags unchanged.
- Backpressure: rsp_ready=0, issue 2 ops with RSP_DEPTH=2.
  - After the second acceptance req_ready=0 even though state is IDLE after completion.
  - Hold rsp_ready=1 one cycle: req_ready returns next cycle; responses delivered in order.
- Flush in WAIT: flush one cycle after enable, FPU ready 4 cycles later with flags=00001.
  - No response; fflags stays 0; busy until ready, then IDLE.
- Flag clear race: pop flags=10000 while fflags=00100 and fflags_clr=1 → fflags=10000.
- Reset mid-op: reset asserted in WAIT, FPU ready arrives after reset deasserts.
  - No response; all outputs at reset values; the next request is processed normally.
